cyc_account_ctrl: RTL and testbench

Sequencer and arbiter in front of the cycle-accounting counter bank. It accepts hardware "switch" and "sample" operations from core-side context tracking. A switch retargets the counter that is currently incrementing. A sample reads a full 64-bit counter value tear-free. The block shares the bank's single SRAM-like port with the CSR file, and CSR accesses always have priority.

---
 rtl/cyc_account_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_cyc_account_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cyc_account_ctrl.sv
// cyc_account_ctrl: sequencer/arbiter in front of the cycle-accounting counter bank.
// Turns core-side "switch" (retarget the incrementing counter) and "sample" (tear-free
// 64-bit read) operations into bank port cycles, sharing the single port with the CSR
// file, which always wins.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   op_valid_i/op_ready_o         operation handshake (op_sample_i: 1 = sample, 0 = switch)
//   op_idx_i                      target counter index
//   rsp_valid_o/rsp_data_o/rsp_err_o  one-cycle completion pulse with held data/error
//   sw_req_i/sw_addr_i/sw_we_i/sw_wdata_i/sw_rdata_o  CSR file access path
//   cnt_addr_o/cnt_we_o/cnt_wdata_o/cnt_rdata_i       bank port (combinational read)
//
// XLEN stands in for the core configuration width and selects the 32/64-bit read sequence.

package cyc_account_ctrl_pkg;

    localparam logic [11:0] CSR_CNT_STATUS = 12'h7C0;
    localparam logic [11:0] CSR_CNT_DATA   = 12'h7C1;
    localparam logic [11:0] CSR_CNT_DATA_H = 12'h7C2;

    // Bank status word layout: bits[31:16] enabled counter, bits[15:0] selected counter
    typedef struct packed {
        logic [15:0] en;
        logic [15:0] sel;
    } cnt_status_t;

endpackage

module cyc_account_ctrl
    import cyc_account_ctrl_pkg::*;
#(
    parameter int unsigned XLEN           = 64,
    parameter int unsigned CycAccountRegs = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            op_valid_i,
    output logic            op_ready_o,
    input  logic            op_sample_i,
    input  logic [3:0]      op_idx_i,
    output logic            rsp_valid_o,
    output logic [63:0]     rsp_data_o,
    output logic            rsp_err_o,
    input  logic            sw_req_i,
    input  logic [11:0]     sw_addr_i,
    input  logic            sw_we_i,
    input  logic [XLEN-1:0] sw_wdata_i,
    output logic [XLEN-1:0] sw_rdata_o,
    output logic [11:0]     cnt_addr_o,
    output logic            cnt_we_o,
    output logic [XLEN-1:0] cnt_wdata_o,
    input  logic [XLEN-1:0] cnt_rdata_i
);

    typedef enum logic [2:0] {
        IDLE,
        WR_STAT,
        RD_H1,
        RD_L,
        RD_H2,
        RESP
    } state_e;

    state_e      state_q, state_d;
    cnt_status_t status_q, status_d;
    logic        sample_q, sample_d;
    logic [3:0]  idx_q, idx_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] hi1_q, hi1_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [63:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;

    cnt_status_t stat_new;
    logic        sw_stat_ok;

    // Status word the FSM writes: switch retargets en, sample retargets sel
    assign stat_new = sample_q ? {status_q.en, 16'(idx_q)} : {16'(idx_q), status_q.sel};

    // Same acceptance rule the bank applies to status writes
    assign sw_stat_ok = (32'(sw_wdata_i[31:16]) < CycAccountRegs) &&
                        (32'(sw_wdata_i[15:0])  < CycAccountRegs);

    assign op_ready_o  = (state_q == IDLE);
    assign sw_rdata_o  = cnt_rdata_i;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            status_q    <= '0;
            sample_q    <= 1'b0;
            idx_q       <= '0;
            lo_q        <= '0;
            hi1_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            status_q    <= status_d;
            sample_q    <= sample_d;
            idx_q       <= idx_d;
            lo_q        <= lo_d;
            hi1_q       <= hi1_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Next-state, port mux and capture logic.
    // A CSR access stalls only the states that need the bank; IDLE (accept only
    // latches) and RESP (no bank access) proceed so the response stays one cycle.
    always_comb begin
        state_d     = state_q;
        status_d    = status_q;
        sample_d    = sample_q;
        idx_d       = idx_q;
        lo_d        = lo_q;
        hi1_d       = hi1_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        cnt_addr_o  = '0;
        cnt_we_o    = 1'b0;
        cnt_wdata_o = '0;

        if (sw_req_i) begin
            cnt_addr_o  = sw_addr_i;
            cnt_we_o    = sw_we_i;
            cnt_wdata_o = sw_wdata_i;
            if (sw_we_i && (sw_addr_i == CSR_CNT_STATUS) && sw_stat_ok) begin
                status_d = cnt_status_t'(sw_wdata_i[31:0]);
            end
        end

        case (state_q)
            IDLE: begin
                if (op_valid_i) begin
                    if (32'(op_idx_i) >= CycAccountRegs) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = '0;
                        rsp_err_d   = 1'b1;
                    end else begin
                        sample_d = op_sample_i;
                        idx_d    = op_idx_i;
                        state_d  = WR_STAT;
                    end
                end
            end
            WR_STAT: begin
                if (!sw_req_i) begin
                    cnt_we_o    = 1'b1;
                    cnt_addr_o  = CSR_CNT_STATUS;
                    cnt_wdata_o = XLEN'(stat_new);
                    status_d    = stat_new;
                    if (sample_q) begin
                        state_d = (XLEN == 64) ? RD_L : RD_H1;
                    end else begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = '0;
                        rsp_err_d   = 1'b0;
                    end
                end
            end
            RD_H1: begin
                if (!sw_req_i) begin
                    cnt_addr_o = CSR_CNT_DATA_H;
                    hi1_d      = cnt_rdata_i[31:0];
                    state_d    = RD_L;
                end
            end
            RD_L: begin
                if (!sw_req_i) begin
                    cnt_addr_o = CSR_CNT_DATA;
                    lo_d       = cnt_rdata_i[31:0];
                    if (XLEN == 64) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = 64'(cnt_rdata_i);
                        rsp_err_d   = 1'b0;
                    end else begin
                        state_d = RD_H2;
                    end
                end
            end
            RD_H2: begin
                if (!sw_req_i) begin
                    cnt_addr_o = CSR_CNT_DATA_H;
                    // High word moved between reads: low word may have wrapped, re-read it
                    if (cnt_rdata_i[31:0] == hi1_q) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = {cnt_rdata_i[31:0], lo_q};
                        rsp_err_d   = 1'b0;
                    end else begin
                        hi1_d   = cnt_rdata_i[31:0];
                        state_d = RD_L;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cyc_account_ctrl.sv
// Directed bench for cyc_account_ctrl: one 64-bit and one 32-bit instance, each in
// front of a small behavioural counter bank (status register, 8 counters, the enabled
// counter increments every cycle without a bank write).
module tb_cyc_account_ctrl;
    import cyc_account_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        bank_clr;
    int          n_cmp = 0;
    int          n_bad = 0;

    // Index 0: XLEN = 64 instance, index 1: XLEN = 32 instance
    logic        op_valid [2];
    logic        op_ready [2];
    logic        op_sample[2];
    logic [3:0]  op_idx   [2];
    logic        rsp_valid[2];
    logic [63:0] rsp_data [2];
    logic        rsp_err  [2];
    logic        sw_req   [2];
    logic [11:0] sw_addr  [2];
    logic        sw_we    [2];
    logic [11:0] cnt_addr [2];
    logic        cnt_we   [2];
    logic [63:0] sw_wdata0, sw_rdata0, cnt_wdata0, cnt_rdata0;
    logic [31:0] sw_wdata1, sw_rdata1, cnt_wdata1, cnt_rdata1;

    cyc_account_ctrl #(.XLEN(64), .CycAccountRegs(8)) u_dut64 (
        .clk_i(clk), .rst_ni(rst_n),
        .op_valid_i(op_valid[0]), .op_ready_o(op_ready[0]),
        .op_sample_i(op_sample[0]), .op_idx_i(op_idx[0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_data_o(rsp_data[0]), .rsp_err_o(rsp_err[0]),
        .sw_req_i(sw_req[0]), .sw_addr_i(sw_addr[0]), .sw_we_i(sw_we[0]),
        .sw_wdata_i(sw_wdata0), .sw_rdata_o(sw_rdata0),
        .cnt_addr_o(cnt_addr[0]), .cnt_we_o(cnt_we[0]),
        .cnt_wdata_o(cnt_wdata0), .cnt_rdata_i(cnt_rdata0)
    );

    cyc_account_ctrl #(.XLEN(32), .CycAccountRegs(8)) u_dut32 (
        .clk_i(clk), .rst_ni(rst_n),
        .op_valid_i(op_valid[1]), .op_ready_o(op_ready[1]),
        .op_sample_i(op_sample[1]), .op_idx_i(op_idx[1]),
        .rsp_valid_o(rsp_valid[1]), .rsp_data_o(rsp_data[1]), .rsp_err_o(rsp_err[1]),
        .sw_req_i(sw_req[1]), .sw_addr_i(sw_addr[1]), .sw_we_i(sw_we[1]),
        .sw_wdata_i(sw_wdata1), .sw_rdata_o(sw_rdata1),
        .cnt_addr_o(cnt_addr[1]), .cnt_we_o(cnt_we[1]),
        .cnt_wdata_o(cnt_wdata1), .cnt_rdata_i(cnt_rdata1)
    );

    // Behavioural counter bank
    logic [63:0] mem [2][8];
    logic [15:0] b_en [2];
    logic [15:0] b_sel[2];
    logic [63:0] wd   [2];

    assign wd[0] = cnt_wdata0;
    assign wd[1] = {32'b0, cnt_wdata1};

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (bank_clr) begin
                b_en[d]  <= '0;
                b_sel[d] <= '0;
                for (int k = 0; k < 8; k++) mem[d][k] <= '0;
            end else if (cnt_we[d]) begin
                case (cnt_addr[d])
                    CSR_CNT_STATUS: begin
                        if (wd[d][31:16] < 16'd8 && wd[d][15:0] < 16'd8) begin
                            b_en[d]  <= wd[d][31:16];
                            b_sel[d] <= wd[d][15:0];
                        end
                    end
                    CSR_CNT_DATA: begin
                        if (d == 0) mem[d][b_sel[d][2:0]] <= wd[d];
                        else        mem[d][b_sel[d][2:0]][31:0] <= wd[d][31:0];
                    end
                    CSR_CNT_DATA_H: mem[d][b_sel[d][2:0]][63:32] <= wd[d][31:0];
                    default: ;
                endcase
            end else begin
                mem[d][b_en[d][2:0]] <= mem[d][b_en[d][2:0]] + 64'd1;
            end
        end
    end

    always_comb begin
        cnt_rdata0 = '0;
        cnt_rdata1 = '0;
        case (cnt_addr[0])
            CSR_CNT_STATUS: cnt_rdata0 = {32'b0, b_en[0], b_sel[0]};
            CSR_CNT_DATA:   cnt_rdata0 = mem[0][b_sel[0][2:0]];
            CSR_CNT_DATA_H: cnt_rdata0 = {32'b0, mem[0][b_sel[0][2:0]][63:32]};
            default: ;
        endcase
        case (cnt_addr[1])
            CSR_CNT_STATUS: cnt_rdata1 = {b_en[1], b_sel[1]};
            CSR_CNT_DATA:   cnt_rdata1 = mem[1][b_sel[1][2:0]][31:0];
            CSR_CNT_DATA_H: cnt_rdata1 = mem[1][b_sel[1][2:0]][63:32];
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] wdat(input int d);
        return (d == 0) ? cnt_wdata0 : {32'b0, cnt_wdata1};
    endfunction

    // One CSR cycle; the request stays asserted until the next driver clears it
    task automatic csr_acc(input int d, input logic we, input logic [11:0] a, input logic [63:0] w);
        @(posedge clk); #1;
        sw_req[d]  = 1'b1;
        sw_we[d]   = we;
        sw_addr[d] = a;
        if (d == 0) sw_wdata0 = w;
        else        sw_wdata1 = w[31:0];
        @(negedge clk);
    endtask

    // Issue one op at cycle T, wait (bounded) for the response, check latency/err/pulse
    task automatic run_op(input int d, input logic s, input logic [3:0] idx, input int exp_lat,
                          input logic exp_err, output logic [63:0] data, output logic we1,
                          output logic [63:0] wd1, output int we_cnt);
        int lat;
        @(posedge clk); #1;
        sw_req[d]    = 1'b0;
        sw_we[d]     = 1'b0;
        op_valid[d]  = 1'b1;
        op_sample[d] = s;
        op_idx[d]    = idx;
        @(negedge clk);
        chk("op_ready", 64'(op_ready[d]), 64'd1);
        @(posedge clk); #1;
        op_valid[d] = 1'b0;
        lat = 1; we_cnt = 0; we1 = 1'b0; wd1 = '0;
        while (lat < 30) begin
            @(negedge clk);
            if (lat == 1) begin
                we1 = cnt_we[d];
                wd1 = wdat(d);
            end
            if (cnt_we[d]) we_cnt++;
            if (rsp_valid[d]) break;
            @(posedge clk); #1;
            lat++;
        end
        chk("rsp_lat", 64'(lat), 64'(exp_lat));
        chk("rsp_err", 64'(rsp_err[d]), 64'(exp_err));
        data = rsp_data[d];
        @(posedge clk);
        @(negedge clk);
        chk("rsp_pulse", 64'(rsp_valid[d]), 64'd0);
    endtask

    logic [63:0] data, wd1;
    logic        we1;
    int          wec;
    int          seen;

    initial begin
        rst_n = 1'b0; bank_clr = 1'b1;
        for (int d = 0; d < 2; d++) begin
            op_valid[d] = 1'b0; op_sample[d] = 1'b0; op_idx[d] = '0;
            sw_req[d] = 1'b0; sw_we[d] = 1'b0; sw_addr[d] = '0;
        end
        sw_wdata0 = '0; sw_wdata1 = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready",  64'(op_ready[d]),  64'd1);
            chk("rst_rvalid", 64'(rsp_valid[d]), 64'd0);
            chk("rst_rdata",  rsp_data[d],       64'd0);
            chk("rst_rerr",   64'(rsp_err[d]),   64'd0);
            chk("rst_we",     64'(cnt_we[d]),    64'd0);
            chk("rst_addr",   64'(cnt_addr[d]),  64'd0);
        end
        rst_n = 1'b1; bank_clr = 1'b0;

        // Switch to counter 3, then two samples of it
        run_op(0, 1'b0, 4'd3, 2, 1'b0, data, we1, wd1, wec);
        chk("sw3_we",   64'(we1), 64'd1);
        chk("sw3_wd",   wd1, 64'h0003_0000);
        chk("sw3_data", data, 64'd0);
        run_op(0, 1'b1, 4'd3, 3, 1'b0, data, we1, wd1, wec);
        chk("smp3_wd",   wd1, 64'h0003_0003);
        chk("smp3_data", data, 64'd3);
        run_op(0, 1'b1, 4'd3, 3, 1'b0, data, we1, wd1, wec);
        chk("smp3b_data", data, 64'd7);

        // Out-of-range index
        run_op(0, 1'b1, 4'd9, 1, 1'b1, data, we1, wd1, wec);
        chk("err_data", data, 64'd0);
        chk("err_nowe", 64'(wec), 64'd0);

        // Sample with CSR traffic during WR_STAT for three cycles
        fork
            run_op(0, 1'b1, 4'd2, 6, 1'b0, data, we1, wd1, wec);
            begin
                @(posedge clk);
                @(posedge clk); #1;
                sw_req[0] = 1'b1; sw_we[0] = 1'b0; sw_addr[0] = 12'h123;
                @(negedge clk);
                chk("mux_addr1", 64'(cnt_addr[0]), 64'h123);
                chk("mux_we1",   64'(cnt_we[0]),   64'd0);
                @(posedge clk); #1;
                sw_we[0] = 1'b1; sw_addr[0] = 12'h456; sw_wdata0 = 64'hDEAD_BEEF_0000_1111;
                @(negedge clk);
                chk("mux_addr2", 64'(cnt_addr[0]), 64'h456);
                chk("mux_we2",   64'(cnt_we[0]),   64'd1);
                chk("mux_wd2",   cnt_wdata0,       64'hDEAD_BEEF_0000_1111);
                @(posedge clk); #1;
                sw_we[0] = 1'b0; sw_addr[0] = CSR_CNT_STATUS;
                @(negedge clk);
                chk("mux_rdata", sw_rdata0, 64'h0003_0003);
                @(posedge clk); #1;
                sw_req[0] = 1'b0;
                @(negedge clk);
                chk("stall_we", 64'(cnt_we[0]),   64'd1);
                chk("stall_ad", 64'(cnt_addr[0]), 64'(CSR_CNT_STATUS));
                chk("stall_wd", cnt_wdata0,       64'h0003_0002);
            end
        join

        // Shadow acceptance rule on CSR status writes
        csr_acc(0, 1'b1, CSR_CNT_STATUS, 64'h0014_0004);
        run_op(0, 1'b0, 4'd1, 2, 1'b0, data, we1, wd1, wec);
        chk("rej_en_wd", wd1, 64'h0001_0002);
        csr_acc(0, 1'b1, CSR_CNT_STATUS, 64'h0000_0009);
        run_op(0, 1'b1, 4'd0, 3, 1'b0, data, we1, wd1, wec);
        chk("rej_sel_wd", wd1, 64'h0001_0000);
        csr_acc(0, 1'b1, CSR_CNT_STATUS, 64'h0005_0004);
        run_op(0, 1'b0, 4'd6, 2, 1'b0, data, we1, wd1, wec);
        chk("acc_wd", wd1, 64'h0006_0004);

        // XLEN = 32: preload counter 1 just below a carry, enable it, sample across the carry
        csr_acc(1, 1'b1, CSR_CNT_STATUS, 64'h0000_0001);
        csr_acc(1, 1'b1, CSR_CNT_DATA_H, 64'h0);
        csr_acc(1, 1'b1, CSR_CNT_DATA,   64'hFFFF_FFFE);
        csr_acc(1, 1'b0, CSR_CNT_DATA,   64'h0);
        chk("pre_rd", 64'(sw_rdata1), 64'hFFFF_FFFE);
        csr_acc(1, 1'b1, CSR_CNT_STATUS, 64'h0001_0001);
        run_op(1, 1'b1, 4'd1, 7, 1'b0, data, we1, wd1, wec);
        chk("tear_wd",   wd1, 64'h0001_0001);
        chk("tear_data", data, 64'h0000_0001_0000_0002);
        run_op(1, 1'b1, 4'd1, 5, 1'b0, data, we1, wd1, wec);
        chk("s32_data", data, 64'h0000_0001_0000_0008);
        run_op(1, 1'b0, 4'd12, 1, 1'b1, data, we1, wd1, wec);
        chk("err32_data", data, 64'd0);

        // Reset in the middle of a sample
        run_op(0, 1'b1, 4'd6, 3, 1'b0, data, we1, wd1, wec);
        @(posedge clk); #1;
        op_valid[0] = 1'b1; op_sample[0] = 1'b1; op_idx[0] = 4'd6;
        @(posedge clk); #1;
        op_valid[0] = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_rdl", 64'(cnt_addr[0]), 64'(CSR_CNT_DATA));
        #1 rst_n = 1'b0;
        #1;
        chk("abort_ready",  64'(op_ready[0]),  64'd1);
        chk("abort_rvalid", 64'(rsp_valid[0]), 64'd0);
        chk("abort_rdata",  rsp_data[0],       64'd0);
        chk("abort_we",     64'(cnt_we[0]),    64'd0);
        chk("abort_addr",   64'(cnt_addr[0]),  64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid[0]) seen++;
        end
        chk("abort_norsp", 64'(seen), 64'd0);
        chk("abort_ready2", 64'(op_ready[0]), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
